// File: rtl/qslave2908.sv
// QBUS programmed-I/O slave sequencer driving Am2908 strobe/enable for DATI, DATO(B).
// Optional read-modify-write (DATIO/DATIOB) follow-on write: define QSLAVE_RMW_EN.
`timescale 1ns/1ps
module qslave2908 #(
  parameter logic [12:0] BASE_ADDR = 13'o17150,
  parameter int          NREG_BITS = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 RSYNC,
  input  logic                 RDIN,
  input  logic                 RDOUT,
  input  logic                 RWTBT,
  input  logic                 RBS7,
  input  logic                 RINIT,
  input  logic [12:0]          addr_in,
  output logic                 TRPLY,
  output logic [NREG_BITS-1:0] reg_sel,
  output logic                 reg_rd,
  output logic                 reg_wr,
  output logic [1:0]           wr_byte,
  output logic                 assert_data,
  output logic                 DALst,
  output logic                 DALbe,
  output logic                 selected
);

  typedef enum logic [10:0] {
    IDLE      = 11'b000_0000_0001,
    IGNORE    = 11'b000_0000_0010,
    SEL       = 11'b000_0000_0100,
    RD_FETCH  = 11'b000_0000_1000,
    RD_LOAD   = 11'b000_0001_0000,
    RD_DRIVE  = 11'b000_0010_0000,
    RD_WAIT   = 11'b000_0100_0000,
    RD_HOLD   = 11'b000_1000_0000,
    WR_SETTLE = 11'b001_0000_0000,
    WR_WAIT   = 11'b010_0000_0000,
    DONE      = 11'b100_0000_0000
  } state_t;

  state_t     state_reg;
  logic       wait_reg;
  logic       addr0_reg;
  logic [1:0] rsync_sync_reg;
  logic [1:0] rdin_sync_reg;
  logic [1:0] rdout_sync_reg;
  logic       s_rsync;
  logic       s_rdin;
  logic       s_rdout;
  logic       addr_match;
`ifdef QSLAVE_RMW_EN
  logic       was_read_reg;
  logic       rdout_prev_reg;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsync_sync_reg <= 2'b00;
      rdin_sync_reg  <= 2'b00;
      rdout_sync_reg <= 2'b00;
    end else begin
      rsync_sync_reg <= {rsync_sync_reg[0], RSYNC};
      rdin_sync_reg  <= {rdin_sync_reg[0], RDIN};
      rdout_sync_reg <= {rdout_sync_reg[0], RDOUT};
    end
  end

  assign s_rsync    = rsync_sync_reg[1];
  assign s_rdin     = rdin_sync_reg[1];
  assign s_rdout    = rdout_sync_reg[1];
  assign addr_match = RBS7 && (addr_in[12:NREG_BITS+1] == BASE_ADDR[12:NREG_BITS+1]);

  // Every output is a register toggled by its own set/clear, so none can glitch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || RINIT) begin
      state_reg   <= IDLE;
      wait_reg    <= 1'b0;
      addr0_reg   <= 1'b0;
      TRPLY       <= 1'b0;
      reg_sel     <= '0;
      reg_rd      <= 1'b0;
      reg_wr      <= 1'b0;
      wr_byte     <= 2'b00;
      assert_data <= 1'b0;
      DALst       <= 1'b0;
      DALbe       <= 1'b0;
      selected    <= 1'b0;
`ifdef QSLAVE_RMW_EN
      was_read_reg   <= 1'b0;
      rdout_prev_reg <= 1'b0;
`endif
    end else begin
      reg_rd <= 1'b0;
      reg_wr <= 1'b0;
`ifdef QSLAVE_RMW_EN
      rdout_prev_reg <= s_rdout;
`endif
      case (state_reg)
        IDLE: begin
          if (s_rsync) begin
            if (addr_match) begin
              selected  <= 1'b1;
              reg_sel   <= addr_in[NREG_BITS:1];
              addr0_reg <= addr_in[0];
              state_reg <= SEL;
            end else begin
              state_reg <= IGNORE;
            end
          end
        end
        IGNORE: if (!s_rsync) state_reg <= IDLE;
        SEL: begin
          if (s_rdin) begin
            reg_rd      <= 1'b1;
            assert_data <= 1'b1;
            wait_reg    <= 1'b0;
            state_reg   <= RD_FETCH;
          end else if (s_rdout) begin
            state_reg <= WR_SETTLE;
          end else if (!s_rsync) begin
            selected  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        // Two-cycle dwell gives the device a full cycle to present read data.
        RD_FETCH: begin
          if (wait_reg) begin
            DALst     <= 1'b1;
            state_reg <= RD_LOAD;
          end else begin
            wait_reg <= 1'b1;
          end
        end
        RD_LOAD: begin
          DALst     <= 1'b0;
          DALbe     <= 1'b1;
          wait_reg  <= 1'b0;
          state_reg <= RD_DRIVE;
        end
        RD_DRIVE: begin
          if (wait_reg) begin
            TRPLY     <= 1'b1;
            state_reg <= RD_WAIT;
          end else begin
            wait_reg <= 1'b1;
          end
        end
        RD_WAIT: begin
          if (!s_rdin) begin
            TRPLY     <= 1'b0;
            state_reg <= RD_HOLD;
          end
        end
        RD_HOLD: begin
          DALbe       <= 1'b0;
          assert_data <= 1'b0;
`ifdef QSLAVE_RMW_EN
          was_read_reg <= 1'b1;
`endif
          state_reg   <= DONE;
        end
        WR_SETTLE: begin
          reg_wr    <= 1'b1;
          TRPLY     <= 1'b1;
          wr_byte   <= RWTBT ? {addr0_reg, ~addr0_reg} : 2'b11;
`ifdef QSLAVE_RMW_EN
          was_read_reg <= 1'b0;
`endif
          state_reg <= WR_WAIT;
        end
        WR_WAIT: begin
          if (!s_rdout) begin
            TRPLY     <= 1'b0;
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (!s_rsync) begin
            selected  <= 1'b0;
            state_reg <= IDLE;
`ifdef QSLAVE_RMW_EN
          end else if (was_read_reg && s_rdout && !rdout_prev_reg) begin
            state_reg <= WR_SETTLE;
`endif
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qslave2908.sv
// Self-checking bench for qslave2908: scenario tasks plus a reg_rd/reg_wr scoreboard.
`timescale 1ns/1ps
module tb_qslave2908;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        RSYNC = 1'b0, RDIN = 1'b0, RDOUT = 1'b0, RWTBT = 1'b0, RBS7 = 1'b0, RINIT = 1'b0;
  logic [12:0] addr_in = '0;
  logic        TRPLY, reg_rd, reg_wr, assert_data, DALst, DALbe, selected;
  logic [1:0]  reg_sel, wr_byte;

  int checks = 0;
  int errors = 0;

`ifdef QSLAVE_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  typedef struct {
    logic       is_wr;
    logic [1:0] sel;
    logic [1:0] wb;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  qslave2908 dut (
    .clk(clk), .reset_n(reset_n), .RSYNC(RSYNC), .RDIN(RDIN), .RDOUT(RDOUT),
    .RWTBT(RWTBT), .RBS7(RBS7), .RINIT(RINIT), .addr_in(addr_in),
    .TRPLY(TRPLY), .reg_sel(reg_sel), .reg_rd(reg_rd), .reg_wr(reg_wr),
    .wr_byte(wr_byte), .assert_data(assert_data), .DALst(DALst), .DALbe(DALbe),
    .selected(selected)
  );

  always #25 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: every register strobe must match the next expected transaction.
  always begin
    @(posedge clk);
    #2;
    if (reset_n && (reg_rd || reg_wr)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected rd=%0b wr=%0b sel=%0d, required no strobe", reg_rd, reg_wr, reg_sel);
      end else begin
        mon_e = exp_q.pop_front();
        if ({reg_wr, reg_rd, reg_sel} !== {mon_e.is_wr, ~mon_e.is_wr, mon_e.sel} ||
            (mon_e.is_wr && wr_byte !== mon_e.wb)) begin
          errors++;
          $display("FAIL sb_txn got wr=%0b rd=%0b sel=%0d wb=%b, required wr=%0b sel=%0d wb=%b",
                   reg_wr, reg_rd, reg_sel, wr_byte, mon_e.is_wr, mon_e.sel, mon_e.wb);
        end
      end
    end
  end

  task automatic do_read(input logic [12:0] a, input string tag);
    int t_rd, t_st, t_be, t_rp, st_cnt, n, n_fall;
    logic held;
    exp_q.push_back('{1'b0, a[2:1], 2'b00});
    addr_in = a; RBS7 = 1'b1; RSYNC = 1'b1;
    tick(4);
    checks++;
    if (selected !== 1'b1 || reg_sel !== a[2:1]) begin
      errors++;
      $display("FAIL %s_select got sel=%0b reg_sel=%0d, required 1/%0d", tag, selected, reg_sel, a[2:1]);
    end
    RDIN = 1'b1;
    t_rd = -1; t_st = -1; t_be = -1; t_rp = -1; st_cnt = 0;
    for (n = 0; n < 20 && t_rp < 0; n++) begin
      tick(1);
      if (reg_rd && t_rd < 0) t_rd = n;
      if (DALst) begin st_cnt++; if (t_st < 0) t_st = n; end
      if (DALbe && t_be < 0) t_be = n;
      if (TRPLY && t_rp < 0) t_rp = n;
    end
    checks++;
    if (t_rd < 0 || t_rp < 0) begin
      errors++;
      $display("FAIL %s_timeout got rd_at=%0d trply_at=%0d, required both seen", tag, t_rd, t_rp);
    end else begin
      checks++;
      if (t_st - t_rd != 2 || st_cnt != 1) begin
        errors++;
        $display("FAIL %s_dalst got offset=%0d cycles=%0d, required +2 for 1", tag, t_st - t_rd, st_cnt);
      end
      checks++;
      if (t_be - t_rd != 3) begin
        errors++;
        $display("FAIL %s_dalbe_rise got +%0d, required +3", tag, t_be - t_rd);
      end
      checks++;
      if (t_rp - t_rd != 5 || assert_data !== 1'b1) begin
        errors++;
        $display("FAIL %s_trply_rise got +%0d assert_data=%0b, required +5/1", tag, t_rp - t_rd, assert_data);
      end
    end
    held = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(1); if (TRPLY !== 1'b1 || DALbe !== 1'b1) held = 1'b0; end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL %s_trply_hold got 0, required 1 while RDIN high", tag);
    end
    RDIN = 1'b0;
    n_fall = -1;
    for (n = 1; n <= 10 && n_fall < 0; n++) begin tick(1); if (!TRPLY) n_fall = n; end
    checks++;
    if (n_fall < 2 || n_fall > 4 || DALbe !== 1'b1) begin
      errors++;
      $display("FAIL %s_trply_fall got %0d cycles dalbe=%0b, required 2..4 with DALbe 1", tag, n_fall, DALbe);
    end
    tick(1);
    checks++;
    if (DALbe !== 1'b0 || assert_data !== 1'b0) begin
      errors++;
      $display("FAIL %s_dalbe_fall got dalbe=%0b ad=%0b, required 0/0", tag, DALbe, assert_data);
    end
    RSYNC = 1'b0;
    tick(5);
    checks++;
    if (selected !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_end got sel=%0b pending=%0d, required 0/0", tag, selected, exp_q.size());
    end
  endtask

  task automatic do_write(input logic [12:0] a, input logic bytem, input logic [1:0] wb, input string tag);
    int n_wr, n_fall, n;
    logic rp_at_wr, held;
    exp_q.push_back('{1'b1, a[2:1], wb});
    addr_in = a; RBS7 = 1'b1; RSYNC = 1'b1;
    tick(4);
    RWTBT = bytem; RDOUT = 1'b1;
    n_wr = -1; rp_at_wr = 1'b0;
    for (n = 1; n <= 10 && n_wr < 0; n++) begin
      tick(1);
      if (reg_wr) begin n_wr = n; rp_at_wr = TRPLY; end
    end
    checks++;
    if (n_wr < 3 || n_wr > 5 || rp_at_wr !== 1'b1) begin
      errors++;
      $display("FAIL %s_wr_latency got %0d trply=%0b, required 3..5 with TRPLY 1", tag, n_wr, rp_at_wr);
    end
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin tick(1); if (TRPLY !== 1'b1 || reg_wr !== 1'b0) held = 1'b0; end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL %s_trply_hold got drop or repeat strobe, required TRPLY held, one pulse", tag);
    end
    RDOUT = 1'b0; RWTBT = 1'b0;
    n_fall = -1;
    for (n = 1; n <= 10 && n_fall < 0; n++) begin tick(1); if (!TRPLY) n_fall = n; end
    checks++;
    if (n_fall < 2 || n_fall > 4) begin
      errors++;
      $display("FAIL %s_trply_fall got %0d cycles, required 2..4", tag, n_fall);
    end
    RSYNC = 1'b0;
    tick(5);
    checks++;
    if (selected !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_end got sel=%0b pending=%0d, required 0/0", tag, selected, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(3);
    checks++;
    if ({TRPLY, reg_rd, reg_wr, wr_byte, assert_data, DALst, DALbe, selected, reg_sel} !== 11'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b, required 0", {TRPLY, reg_rd, reg_wr, wr_byte, assert_data, DALst, DALbe, selected, reg_sel});
    end
    reset_n = 1'b1;
    tick(3);
  endtask

  task automatic test_no_match(input logic [12:0] a, input logic bs7, input string tag);
    logic seen;
    addr_in = a; RBS7 = bs7; RSYNC = 1'b1;
    tick(4);
    RDIN = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (TRPLY || reg_rd || DALbe || selected || assert_data) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL %s_ignored got activity=1, required 0", tag);
    end
    RDIN = 1'b0; RSYNC = 1'b0; RBS7 = 1'b0;
    tick(5);
  endtask

  task automatic test_rmw();
    logic saw_rp, saw_wr;
    int n;
    exp_q.push_back('{1'b0, 2'd0, 2'b00});
    addr_in = 13'o17150; RBS7 = 1'b1; RSYNC = 1'b1;
    tick(4);
    RDIN = 1'b1;
    for (n = 0; n < 20 && !TRPLY; n++) tick(1);
    RDIN = 1'b0;
    for (n = 0; n < 10 && TRPLY; n++) tick(1);
    tick(3);
    if (RMW) exp_q.push_back('{1'b1, 2'd0, 2'b11});
    RDOUT = 1'b1;
    saw_rp = 1'b0; saw_wr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (TRPLY) saw_rp = 1'b1;
      if (reg_wr) saw_wr = 1'b1;
    end
    checks++;
    if (saw_rp !== RMW || saw_wr !== RMW) begin
      errors++;
      $display("FAIL rmw_dout_reply got trply=%0b wr=%0b, required %0b", saw_rp, saw_wr, RMW);
    end
    RDOUT = 1'b0;
    tick(6);
    RSYNC = 1'b0;
    tick(5);
    checks++;
    if (TRPLY !== 1'b0 || selected !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rmw_end got trply=%0b sel=%0b pending=%0d, required 0/0/0", TRPLY, selected, exp_q.size());
    end
  endtask

  task automatic test_rinit();
    int n;
    exp_q.push_back('{1'b0, 2'd1, 2'b00});
    addr_in = 13'o17152; RBS7 = 1'b1; RSYNC = 1'b1;
    tick(4);
    RDIN = 1'b1;
    for (n = 0; n < 20 && !TRPLY; n++) tick(1);
    RINIT = 1'b1; RDIN = 1'b0; RSYNC = 1'b0;
    tick(1);
    checks++;
    if ({TRPLY, reg_rd, reg_wr, wr_byte, assert_data, DALst, DALbe, selected, reg_sel} !== 11'b0) begin
      errors++;
      $display("FAIL rinit_clear got %b, required 0", {TRPLY, reg_rd, reg_wr, wr_byte, assert_data, DALst, DALbe, selected, reg_sel});
    end
    tick(3);
    RINIT = 1'b0;
    tick(3);
    do_read(13'o17152, "after_rinit");
  endtask

  task automatic test_reset_mid_write();
    int n;
    exp_q.push_back('{1'b1, 2'd2, 2'b11});
    addr_in = 13'o17154; RBS7 = 1'b1; RSYNC = 1'b1;
    tick(4);
    RDOUT = 1'b1;
    for (n = 0; n < 10 && !reg_wr; n++) tick(1);
    tick(1);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({TRPLY, reg_rd, reg_wr, wr_byte, assert_data, DALst, DALbe, selected, reg_sel} !== 11'b0) begin
      errors++;
      $display("FAIL reset_mid_write got %b, required 0", {TRPLY, reg_rd, reg_wr, wr_byte, assert_data, DALst, DALbe, selected, reg_sel});
    end
    RDOUT = 1'b0; RSYNC = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    do_read(13'o17150, "after_reset");
  endtask

  task automatic test_back_to_back();
    do_read(13'o17154, "b2b_read");
    do_write(13'o17150, 1'b0, 2'b11, "b2b_write");
    do_write(13'o17152, 1'b1, 2'b01, "b2b_byte_lo");
  endtask

  initial begin
    test_reset();
    do_read(13'o17152, "dati_17152");
    do_write(13'o17156, 1'b0, 2'b11, "dato_17156");
    do_write(13'o17153, 1'b1, 2'b10, "datob_17153");
    test_no_match(13'o17170, 1'b1, "nomatch_17170");
    test_no_match(13'o17150, 1'b0, "nomatch_bs7");
    do_read(13'o17150, "dati_after_ignore");
    test_rmw();
    test_rinit();
    test_reset_mid_write();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no completion, required finish within 1 ms");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/qslave2908.md
# qslave2908

QBUS slave (responder) sequencer for a device whose bus data path runs through Am2908 transceivers. It recognises programmed-I/O cycles addressed to the device's register window in the I/O page and answers DATI, DATO and DATOB cycles: it latches register data into the Am2908s, drives the bus, asserts TRPLY and releases it. It is the target-side counterpart to the DMA master sequencer and shares the same Am2908 strobe/enable nets (DALst/DALbe), muxed externally by `bus_master`. Address, data and register storage live outside this block.

## Interface
- `BASE_ADDR`, default 13'o17150: I/O-page word address of register 0. Its low `NREG_BITS+1` bits must be zero.
- `NREG_BITS`, default 2: log2 of the register count (4 word registers).
- `clk` in 1: 20 MHz clock, 50 ns per cycle.
- `reset_n` in 1: asynchronous, active-low reset.
- `RSYNC`, `RDIN`, `RDOUT`, `RWTBT`, `RBS7`, `RINIT` in 1: QBUS receivers, asserted-high, asynchronous.
- `addr_in` in 13: low address bits, held in the Am2908 receive latches, which are latched by RSYNC in hardware.
- `TRPLY` out 1: bus reply.
- `reg_sel` out NREG_BITS: selected register, `addr_in[NREG_BITS:1]`.
- `reg_rd` out 1: one-cycle pulse; the device presents read data on the next cycle.
- `reg_wr` out 1: one-cycle pulse; the device captures the received bus data.
- `wr_byte` out 2: byte enables qualifying `reg_wr`; bit 1 is the high byte.
- `assert_data` out 1: steers device read data toward the Am2908 inputs.
- `DALst` out 1: Am2908 driver-register strobe.
- `DALbe` out 1: Am2908 bus enable.
- `selected` out 1: high from address match until RSYNC negation.

## Operation
- RSYNC, RDIN and RDOUT pass through 2-FF synchronisers, giving `sRSYNC`, `sRDIN` and `sRDOUT`.
- Address match: `RBS7 && addr_in[12:NREG_BITS+1] == BASE_ADDR[12:NREG_BITS+1]`. It is sampled once, in IDLE, on the first cycle `sRSYNC` is high.
- One-hot states:
  - **IDLE**:
    - `sRSYNC` with a match: set `selected`, latch `reg_sel` and `addr_in[0]`, go to SEL.
    - `sRSYNC` without a match: go to IGNORE.
  - **IGNORE**: wait for `!sRSYNC`, then go to IDLE.
  - **SEL**:
    - `sRDIN`: pulse `reg_rd`, set `assert_data`, go to RD_FETCH.
    - `sRDOUT`: go to WR_SETTLE.
    - `!sRSYNC`: go to IDLE.
  - **RD_FETCH**: wait 1 cycle, set `DALst`, go to RD_LOAD.
  - **RD_LOAD**: clear `DALst`, set `DALbe`, go to RD_DRIVE.
  - **RD_DRIVE**: after 2 cycles, set `TRPLY`, go to RD_WAIT.
  - **RD_WAIT**: on `!sRDIN`, clear `TRPLY`, go to RD_HOLD.
  - **RD_HOLD**: after 1 cycle, clear `DALbe` and `assert_data`, go to DONE.
  - **WR_SETTLE**: wait 1 cycle, sample `RWTBT`, pulse `reg_wr`, set `TRPLY`, go to WR_WAIT.
    - `wr_byte` is 2'b11 for a word write (`RWTBT` low).
    - For a byte write (`RWTBT` high), `wr_byte` is {addr0, ~addr0}.
  - **WR_WAIT**: on `!sRDOUT`, clear `TRPLY`, go to DONE.
  - **DONE**: on `!sRSYNC`, clear `selected`, go to IDLE. RMW behaviour in DONE is defined under Configuration.
- Every output is set or cleared by registered set/clear controls, so nothing glitches.
- RINIT is a synchronous clear: it overrides every state, forces IDLE and drops all outputs, including `TRPLY`, on the next edge.
- `reset_n` low: all outputs and registers go to 0 and the state goes to IDLE immediately.
- If RDIN and RDOUT are both high in SEL, RDIN wins.

## Timing
- Reset value of every output is 0.
- Read cycle, counting from the first cycle `sRDIN` is high:
  - `reg_rd` is high at that edge (+0).
  - `DALst` is high for one cycle at +2.
  - `DALbe` goes high at +3.
  - `TRPLY` goes high at +5, which puts data on the bus 100 ns before RPLY.
- `TRPLY` falls 1 cycle after `sRDIN` falls. `DALbe` falls 1 cycle after that.
- Write cycle: `reg_wr` and `TRPLY` assert together, 1 cycle after `sRDOUT` is first seen. Data has then been valid for at least 150 ns past DOUT.
- Synchroniser latency is 2 to 3 cycles from any bus edge.
- No slave timeout exists: the block waits indefinitely for RDIN, RDOUT or RSYNC negation.

## Configuration
- `QSLAVE_RMW_EN`:
  - Defined: in DONE after a read, if `sRSYNC` is still high and `sRDOUT` rises, go to WR_SETTLE using the latched `reg_sel` (DATIO/DATIOB).
  - Undefined: in DONE the block only waits for `!sRSYNC`. A DOUT there gets no reply and the master takes an NXM.

## Test plan
- DATI to 17152 (RBS7=1), device data 16'o123456 → `reg_sel`=1, `reg_rd` pulse, `DALst` at +2, `DALbe` at +3, `TRPLY` at +5. `TRPLY` drops 1 cycle after RDIN negates; `DALbe` drops 1 cycle later.
- DATO word to 17156 → one `reg_wr` pulse with `wr_byte`=2'b11, `reg_sel`=3. `TRPLY` is held until RDOUT negates.
- DATOB to 17153 with RWTBT high during DOUT → `wr_byte`=2'b10, `reg_sel`=1.
- DATI to 17170, and DATI to 17150 with RBS7=0 → `TRPLY`, `reg_rd` and `DALbe` stay 0; the block returns to IDLE after RSYNC negates.
- DATIO to 17150 → with `QSLAVE_RMW_EN`, a read reply followed by `reg_wr` with `TRPLY` on the DOUT. Without it, no second `TRPLY`.
- RINIT asserted during RD_WAIT, and separately `reset_n` low mid-write → all outputs 0 (RINIT on the next edge, `reset_n` immediately). The next DATI completes normally.
